// File: rtl/filter_window_scheduler_if.sv
// filter_window_scheduler_if: pixel stream, window and output handshake bundle
// master drives pix_in/pix_in_valid/filt_pixel/out_ready; slave (the scheduler)
// drives pix_in_ready/win_out/pix_out/out_valid.
interface filter_window_scheduler_if;
  logic [7:0]  pix_in;
  logic        pix_in_valid;
  logic        pix_in_ready;
  logic [71:0] win_out;
  logic [7:0]  filt_pixel;
  logic [7:0]  pix_out;
  logic        out_valid;
  logic        out_ready;
  modport master (
    output pix_in, pix_in_valid, filt_pixel, out_ready,
    input  pix_in_ready, win_out, pix_out, out_valid
  );
  modport slave (
    input  pix_in, pix_in_valid, filt_pixel, out_ready,
    output pix_in_ready, win_out, pix_out, out_valid
  );
endinterface

// File: rtl/filter_window_scheduler.sv
// filter_window_scheduler: raster-scan 3x3 window scheduler for a median filter
// Ports: clk, rst_n (async active-low), start (frame pulse), busy, done (frame pulse),
// bus (slave modport: pixel input handshake, win_out to datapath, filt_pixel back,
// pix_out/out_valid/out_ready output handshake).
// Optional FILTER_WIN_BYPASS_EN adds input bypass: pix_out becomes the window centre.
module filter_window_scheduler #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef FILTER_WIN_BYPASS_EN
  input  logic bypass,
`endif
  filter_window_scheduler_if.slave bus,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    win [9];
  logic [7:0]    line_a [IMG_W];
  logic [7:0]    line_b [IMG_W];
  logic          xfer, last_col, last_pix, qual;
  assign bus.pix_in_ready = (state == FILL || state == RUN) && (!bus.out_valid || bus.out_ready);
  assign xfer     = bus.pix_in_valid && bus.pix_in_ready;
  assign last_col = col == CW'(IMG_W - 1);
  assign last_pix = last_col && row == RW'(IMG_H - 1);
  assign qual     = row >= RW'(2) && col >= CW'(2);
  assign busy     = state != IDLE;
  assign done     = state == FLUSH && (!bus.out_valid || bus.out_ready);
`ifdef FILTER_WIN_BYPASS_EN
  assign bus.pix_out = bypass ? win[4] : bus.filt_pixel;
`else
  assign bus.pix_out = bus.filt_pixel;
`endif
  for (genvar g = 0; g < 9; g++) begin : g_win
    assign bus.win_out[g*8 +: 8] = win[g];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      bus.out_valid <= 1'b0;
      for (int k = 0; k < 9; k++) win[k] <= '0;
    end else begin
      state <= state == IDLE ? (start ? FILL : IDLE) :
               state == FILL ? (xfer && last_col && row == RW'(1) ? RUN : FILL) :
               state == RUN  ? (xfer && last_pix ? FLUSH : RUN) :
               (done ? IDLE : FLUSH);
      if (state == IDLE && start) begin
        col <= '0;
        row <= '0;
      end else if (xfer) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
      end
      if (xfer) bus.out_valid <= qual;
      else if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (xfer) begin
        for (int k = 0; k < 3; k++) begin
          win[k*3]   <= win[k*3+1];
          win[k*3+1] <= win[k*3+2];
        end
        win[2] <= line_a[col];
        win[5] <= line_b[col];
        win[8] <= bus.pix_in;
      end
    end
  end
  // line_a holds row-2, line_b row-1; contents are never read for an output
  // before being rewritten in the current frame, so no reset is needed
  always_ff @(posedge clk) begin
    if (xfer) begin
      line_a[col] <= line_b[col];
      line_b[col] <= bus.pix_in;
    end
  end
endmodule

// File: doc/filter_window_scheduler.md
FILTER_WINDOW_SCHEDULER -- requirements
Module: filter_window_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 8, image width in pixels (legal range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 8, image height in lines (legal range 3..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-006 SHALL have port pix_in  input  8  raster-order input pixel.
REQ-007 SHALL have port pix_in_valid  input  1  pix_in is valid.
REQ-008 SHALL have port pix_in_ready  output  1  block accepts pix_in; a transfer occurs when valid and ready are both high.
REQ-009 SHALL have port win_out  output  72  3x3 window to the median datapath; byte (i*3+j) at bits [(i*3+j)*8 +: 8]; i=0 is the oldest row, j=0 is the leftmost column.
REQ-010 SHALL have port filt_pixel  input  8  median returned combinationally by the datapath for the current win_out.
REQ-011 SHALL have port pix_out  output  8  filtered pixel, equal to filt_pixel.
REQ-012 SHALL have port out_valid  output  1  pix_out is valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts pix_out.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a frame completes.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN and FLUSH.
REQ-017 SHALL move IDLE->FILL on start, FILL->RUN on the transfer that completes line 1, RUN->FLUSH on the transfer of pixel (IMG_H-1, IMG_W-1), and FLUSH->IDLE once out_valid is low or its transfer completes; done SHALL pulse on the FLUSH->IDLE cycle.
REQ-018 SHALL drive pix_in_ready = (state is FILL or RUN) and (!out_valid or out_ready).
REQ-019 SHALL keep column and row counters that advance only on an input transfer; col wraps from IMG_W-1 to 0 and increments row; both clear on start.
REQ-020 SHALL keep two line buffers of IMG_W bytes holding the previous two lines; on each transfer at column c it SHALL shift the column {lineA[c], lineB[c], pix_in} into the window registers and write the line buffers.
REQ-021 SHALL set out_valid on the cycle after a transfer at row>=2 and col>=2 (latency 1), and SHALL clear it on the cycle after a transfer at col<2 or after an output transfer with no new qualifying input.
REQ-022 SHALL hold win_out and out_valid stable while out_valid=1 and out_ready=0, so no output is lost or duplicated under backpressure.
REQ-023 SHALL produce exactly (IMG_W-2)*(IMG_H-2) outputs per frame in raster order; border pixels produce no output.
REQ-024 SHALL ignore start outside IDLE; start and the final output transfer in the same cycle SHALL leave the block in IDLE with done pulsed and start dropped.
REQ-025 SHALL ignore pix_in_valid in IDLE and FLUSH; counter widths SHALL be clog2 of the parameter.

Reset
REQ-026 SHALL, on rst_n low at any time, including mid-frame, force state IDLE, counters 0, win_out 0, pix_in_ready 0, out_valid 0, busy 0 and done 0; pending outputs are discarded.
REQ-027 Line-buffer contents are not reset; no output SHALL depend on them before they are rewritten in the current frame.

Configuration
REQ-028 With FILTER_WIN_BYPASS_EN defined, the block SHALL add input bypass (1 bit); while bypass=1, pix_out SHALL be the window centre byte (index 4) instead of filt_pixel.
REQ-029 Without FILTER_WIN_BYPASS_EN, the bypass port SHALL be absent and pix_out SHALL always equal filt_pixel.

Verification
REQ-030 IMG_W=4, IMG_H=4, ramp 0..15, out_ready=1, behavioural median model -> outputs 5, 6, 9, 10 in that order; then done pulses once and busy drops.
REQ-031 Same frame with out_ready toggling 1/0 every cycle -> same four values, none repeated, with pix_in_ready low whenever out_valid=1 and out_ready=0.
REQ-032 Window at the first output (after pixel 10) -> win_out bytes 0..8 = 0,1,2,4,5,6,8,9,10.
REQ-033 rst_n low after pixel 7, then a new start with a ramp 100..115 -> outputs 105, 106, 109, 110 with no residue from the first frame.
REQ-034 start pulsed during RUN -> no effect; the frame completes normally with four outputs.
REQ-035 With FILTER_WIN_BYPASS_EN, bypass=1, and filt_pixel forced to 0xFF -> outputs 5, 6, 9, 10.
